fp_addsub_pipe: RTL and testbench
=================================

# fp_addsub_pipe

Pipelined, parametrised IEEE-754 binary floating-point adder/subtractor for the F-extension datapath of the rv32imf core. It is the successor of the single-cycle combinational adder. Over that adder it adds:
- generic exponent/mantissa widths;
- a 3-stage pipeline with valid/ready backpressure and flush;
- full subnormal support and all five RISC-V rounding modes;
- RISC-V canonical-NaN handling and accrued exception flags.

It sits between the FP issue logic and the FP writeback arbiter, and is also instantiated inside the fsqrt iteration block.

## Interface
Parameters:
- EXP_W, default 8, exponent width.
- MAN_W, default 23, stored fraction width (single precision at defaults).
- TAG_W, default 5, width of the opaque tag (destination register ID) carried alongside each operation.

Ports (FLEN = 1+EXP_W+MAN_W):
- clk  in  1  clock; all state changes on the rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  operand set is valid.
- in_ready  out  1  block accepts the operand set this cycle.
- sub  in  1  1 = A − B, 0 = A + B.
- a, b  in  FLEN  operands.
- rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101–111 are treated as RNE.
- in_tag  in  TAG_W  passed through unchanged.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- result  out  FLEN  rounded sum.
- fflags  out  5  {NV, DZ, OF, UF, NX}; DZ is always 0.
- out_tag  out  TAG_W  tag of the result.

## Operation
Stage 1, unpack/align (S1):
- Classify each operand as zero, subnormal, normal, inf, qNaN or sNaN.
- Effective sign of B = b[FLEN-1] ^ sub.
- Subnormals use exponent 1 with hidden bit 0.
- Swap operands so the larger magnitude is first.
- Shift the smaller significand right by the exponent difference, saturated at MAN_W+3. Bits shifted out are OR-ed into sticky.
- Datapath width is MAN_W+1 significand bits plus G, R, S, plus one carry bit.

Stage 2, add/normalise (S2):
- Add or subtract the magnitudes; the result sign is the sign of the larger operand.
- On carry-out: shift right by 1 (sticky absorbs the lost bit) and increment the exponent.
- Otherwise: leading-zero count, then shift left by min(lzc, exp−1). If the result reaches exponent 1 with hidden bit 0, it is subnormal.
- Exponent arithmetic is signed, EXP_W+2 bits.

Stage 3, round/pack (S3):
- Increment decision per rm from G, R, S, LSB and sign.
- Mantissa carry-out increments the exponent; a subnormal that rounds up to the hidden bit becomes the minimum normal.
- NX = G|R|S.
- Overflow (exponent ≥ 2^EXP_W−1 after rounding) sets OF and NX. The result depends on rm:
  - RNE/RMM → ±inf.
  - RTZ → ±max finite.
  - RDN → +max finite for positive, −inf for negative.
  - RUP → +inf for positive, −max finite for negative.
- UF is set only when the result is tiny after rounding AND inexact.

Special cases (resolved in S1, carried through as a forced result):
- Any NaN input → canonical NaN (0, all-ones exponent, fraction MSB 1, rest 0). NV is set if either input is an sNaN.
- inf − inf (effective) → canonical NaN with NV.
- inf ± finite → that inf.
- Exact zero result from unlike signs → +0, except −0 under RDN. Like-signed zeros keep their sign.

## Timing
- Latency is exactly 3 cycles from the accept edge to out_valid with no backpressure. Throughput is 1 op/cycle.
- Global stall = out_valid & ~out_ready. While stalled, all stage registers hold and in_ready = 0. Otherwise in_ready = 1.
- An operation is accepted on an edge where in_valid & in_ready. Result transfer happens when out_valid & out_ready.
- Results leave in acceptance order and are never dropped or duplicated.
- flush clears all stage valid bits on the next edge, even while stalled. An in_valid asserted in the same cycle as flush is not accepted (in_ready = 0 while flush = 1).
- Reset (asynchronous, mid-operation included): all stage valid bits 0, so out_valid = 0. result, fflags and out_tag are 0; in_ready = 1 after deassertion.
- Outputs are registered. result, fflags and out_tag hold stable while out_valid & ~out_ready.

## Test plan
- 0x3F800000 + 0x40000000, RNE → result 0x40400000, fflags 00000, 3 cycles after accept; tag preserved.
- 0x3F800000 + 0x33800000 → RNE 0x3F800000 with fflags 00001 (tie-to-even); RUP 0x3F800001 with NX. 0x3F800000 − 0x3F800000 → RNE 0x00000000, RDN 0x80000000.
- 0x7F7FFFFF + 0x7F7FFFFF → RNE 0x7F800000 with fflags 00101; RTZ 0x7F7FFFFF with 00101.
- Specials:
  - 0x7F800000 − 0x7F800000 → 0x7FC00000 with 10000.
  - 0x7F800001 + 0x3F800000 → 0x7FC00000 with 10000.
  - 0x7FC00000 + 1.0 → 0x7FC00000 with 00000.
- Subnormals: 0x00000001 + 0x00000001 → 0x00000002 with 00000. 0x00800000 − 0x00000001 → 0x007FFFFF with 00000.
- Push 6 back-to-back ops with out_ready = 0 → in_ready drops after 3 accepts. Release out_ready → all 6 emerge in order. Then assert flush with 2 ops in flight → neither appears. Pulse reset_n low mid-stream → out_valid = 0 immediately.

Source files
------------

// File: rtl/fp_addsub_pipe.sv
// Three-stage IEEE-754 adder/subtractor: unpack/align, add/normalise, round/pack.
// One global stall freezes every stage while the output waits on the consumer.
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 5,
    localparam int FLEN = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [FLEN-1:0]  a,
    input  logic [FLEN-1:0]  b,
    input  logic [2:0]       rm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [FLEN-1:0]  result,
    output logic [4:0]       fflags,
    output logic [TAG_W-1:0] out_tag
);
    // SE: hidden bit + fraction + guard/round/sticky
    localparam int SE  = MAN_W + 4;
    localparam int SHW = $clog2(SE + 1);
    localparam int EW  = EXP_W + 2;
    localparam logic signed [EW-1:0] EXP_OVF = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0] ONE_E   = EW'(1);
    localparam logic [FLEN-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    function automatic logic [SHW-1:0] lzc(input logic [SE-1:0] v);
        lzc = SHW'(SE);
        for (int i = 0; i < SE; i++) begin
            if (v[i]) lzc = SHW'(SE - 1 - i);
        end
    endfunction

    logic stall;

    // Stage 1 registers
    logic             valid1_q, sign1_q, effSub1_q, force1_q, forceNv1_q;
    logic [TAG_W-1:0] tag1_q;
    logic [2:0]       rm1_q;
    logic [EXP_W-1:0] exp1_q;
    logic [SE-1:0]    sigL1_q, sigS1_q;
    logic [FLEN-1:0]  forceRes1_q;

    // Stage 2 registers
    logic                 valid2_q, sign2_q, effSub2_q, force2_q, forceNv2_q;
    logic [TAG_W-1:0]     tag2_q;
    logic [2:0]           rm2_q;
    logic signed [EW-1:0] exp2_q;
    logic [SE-1:0]        man2_q;
    logic [FLEN-1:0]      forceRes2_q;

    // Output registers
    logic             valid3_q;
    logic [FLEN-1:0]  result_q;
    logic [4:0]       fflags_q;
    logic [TAG_W-1:0] tag3_q;

    assign stall     = valid3_q & ~out_ready;
    assign in_ready  = ~stall & ~flush;
    assign out_valid = valid3_q;
    assign result    = result_q;
    assign fflags    = fflags_q;
    assign out_tag   = tag3_q;

    // ---------------- Stage 1: unpack, classify, swap, align ----------------
    logic [EXP_W-1:0]  expA, expB, eA, eB, eL, eS, diff;
    logic [MAN_W-1:0]  fracA, fracB;
    logic [MAN_W:0]    sigA, sigB, sigL, sigS;
    logic              signA, signB, signL, aBig;
    logic              nanA, nanB, snanA, snanB, infA, infB;
    logic [SHW-1:0]    shamt;
    logic [2*SE-1:0]   wide;
    logic [SE-1:0]     alignS;
    logic [2:0]        rm_d;
    logic              force_d, forceNv_d;
    logic [FLEN-1:0]   forceRes_d;

    always_comb begin
        expA  = a[FLEN-2:MAN_W];
        expB  = b[FLEN-2:MAN_W];
        fracA = a[MAN_W-1:0];
        fracB = b[MAN_W-1:0];
        signA = a[FLEN-1];
        signB = b[FLEN-1] ^ sub;
        nanA  = (&expA) & (|fracA);
        nanB  = (&expB) & (|fracB);
        snanA = nanA & ~fracA[MAN_W-1];
        snanB = nanB & ~fracB[MAN_W-1];
        infA  = (&expA) & ~(|fracA);
        infB  = (&expB) & ~(|fracB);
        sigA  = {|expA, fracA};
        sigB  = {|expB, fracB};
        eA    = (|expA) ? expA : EXP_W'(1);
        eB    = (|expB) ? expB : EXP_W'(1);
        aBig  = a[FLEN-2:0] >= b[FLEN-2:0];
        signL = aBig ? signA : signB;
        eL    = aBig ? eA : eB;
        eS    = aBig ? eB : eA;
        sigL  = aBig ? sigA : sigB;
        sigS  = aBig ? sigB : sigA;
        diff  = eL - eS;
        shamt = (32'(diff) > MAN_W + 3) ? SHW'(MAN_W + 3) : SHW'(diff);
        wide  = {sigS, 3'b000, {SE{1'b0}}} >> shamt;
        alignS    = wide[2*SE-1:SE];
        alignS[0] = alignS[0] | (|wide[SE-1:0]);
        rm_d  = (rm > 3'd4) ? 3'd0 : rm;

        force_d    = 1'b0;
        forceNv_d  = 1'b0;
        forceRes_d = '0;
        if (nanA || nanB) begin
            force_d    = 1'b1;
            forceNv_d  = snanA | snanB;
            forceRes_d = CANON_NAN;
        end else if (infA && infB && (signA != signB)) begin
            force_d    = 1'b1;
            forceNv_d  = 1'b1;
            forceRes_d = CANON_NAN;
        end else if (infA) begin
            force_d    = 1'b1;
            forceRes_d = {signA, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (infB) begin
            force_d    = 1'b1;
            forceRes_d = {signB, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid1_q    <= 1'b0;
            sign1_q     <= 1'b0;
            effSub1_q   <= 1'b0;
            force1_q    <= 1'b0;
            forceNv1_q  <= 1'b0;
            tag1_q      <= '0;
            rm1_q       <= '0;
            exp1_q      <= '0;
            sigL1_q     <= '0;
            sigS1_q     <= '0;
            forceRes1_q <= '0;
        end else if (flush) begin
            valid1_q <= 1'b0;
        end else if (!stall) begin
            valid1_q    <= in_valid;
            sign1_q     <= signL;
            effSub1_q   <= signA ^ signB;
            force1_q    <= force_d;
            forceNv1_q  <= forceNv_d;
            tag1_q      <= in_tag;
            rm1_q       <= rm_d;
            exp1_q      <= eL;
            sigL1_q     <= {sigL, 3'b000};
            sigS1_q     <= alignS;
            forceRes1_q <= forceRes_d;
        end
    end

    // ---------------- Stage 2: add/subtract and normalise ----------------
    logic [SE:0]          sum;
    logic [SHW-1:0]       lz;
    logic signed [EW-1:0] eIn, eM1, lzE, lsh, exp_d;
    logic [SE-1:0]        man_d;

    always_comb begin
        sum   = effSub1_q ? ({1'b0, sigL1_q} - {1'b0, sigS1_q})
                          : ({1'b0, sigL1_q} + {1'b0, sigS1_q});
        eIn   = EW'(exp1_q);
        eM1   = eIn - ONE_E;
        lz    = lzc(sum[SE-1:0]);
        lzE   = EW'(lz);
        lsh   = '0;
        exp_d = eIn;
        man_d = sum[SE-1:0];
        if (sum[SE]) begin
            man_d = {sum[SE:2], sum[1] | sum[0]};
            exp_d = eIn + ONE_E;
        end else begin
            // Never shift below exponent 1, so tiny results land as subnormals
            lsh   = (lzE < eM1) ? lzE : eM1;
            man_d = sum[SE-1:0] << lsh;
            exp_d = eIn - lsh;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid2_q    <= 1'b0;
            sign2_q     <= 1'b0;
            effSub2_q   <= 1'b0;
            force2_q    <= 1'b0;
            forceNv2_q  <= 1'b0;
            tag2_q      <= '0;
            rm2_q       <= '0;
            exp2_q      <= '0;
            man2_q      <= '0;
            forceRes2_q <= '0;
        end else if (flush) begin
            valid2_q <= 1'b0;
        end else if (!stall) begin
            valid2_q    <= valid1_q;
            sign2_q     <= sign1_q;
            effSub2_q   <= effSub1_q;
            force2_q    <= force1_q;
            forceNv2_q  <= forceNv1_q;
            tag2_q      <= tag1_q;
            rm2_q       <= rm1_q;
            exp2_q      <= exp_d;
            man2_q      <= man_d;
            forceRes2_q <= forceRes1_q;
        end
    end

    // ---------------- Stage 3: round and pack ----------------
    logic                 g, r, s, lsb, inexact, roundUp, carry, hidden, ovf, toInf, zeroSign;
    logic [MAN_W+1:0]     mant;
    logic [MAN_W-1:0]     frac;
    logic signed [EW-1:0] eR;
    logic [EXP_W-1:0]     expField;
    logic [FLEN-1:0]      result_d;
    logic [4:0]           fflags_d;

    always_comb begin
        lsb     = man2_q[3];
        g       = man2_q[2];
        r       = man2_q[1];
        s       = man2_q[0];
        inexact = g | r | s;
        case (rm2_q)
            3'd1:    roundUp = 1'b0;
            3'd2:    roundUp = sign2_q & inexact;
            3'd3:    roundUp = ~sign2_q & inexact;
            3'd4:    roundUp = g;
            default: roundUp = g & (r | s | lsb);
        endcase
        mant     = {1'b0, man2_q[SE-1:3]} + (MAN_W+2)'(roundUp);
        carry    = mant[MAN_W+1];
        hidden   = carry | mant[MAN_W];
        frac     = carry ? '0 : mant[MAN_W-1:0];
        eR       = carry ? exp2_q + ONE_E : exp2_q;
        expField = hidden ? eR[EXP_W-1:0] : '0;
        ovf      = eR >= EXP_OVF;
        toInf    = (rm2_q == 3'd0) || (rm2_q == 3'd4) ||
                   ((rm2_q == 3'd3) && !sign2_q) || ((rm2_q == 3'd2) && sign2_q);
        zeroSign = effSub2_q ? (rm2_q == 3'd2) : sign2_q;

        result_d = {sign2_q, expField, frac};
        fflags_d = {3'b000, ~hidden & inexact, inexact};
        if (force2_q) begin
            result_d = forceRes2_q;
            fflags_d = {forceNv2_q, 4'b0000};
        end else if (~|man2_q) begin
            result_d = {zeroSign, {(FLEN-1){1'b0}}};
            fflags_d = 5'b00000;
        end else if (ovf) begin
            result_d = toInf ? {sign2_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                             : {sign2_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            fflags_d = 5'b00101;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid3_q <= 1'b0;
            result_q <= '0;
            fflags_q <= '0;
            tag3_q   <= '0;
        end else if (flush) begin
            valid3_q <= 1'b0;
        end else if (!stall) begin
            valid3_q <= valid2_q;
            result_q <= result_d;
            fflags_q <= fflags_d;
            tag3_q   <= tag2_q;
        end
    end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: directed vectors with hand-computed results,
// plus backpressure, flush and asynchronous-reset scenarios.
module tb_fp_addsub_pipe;
    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int TAG_W = 5;
    localparam int FLEN  = 32;

    logic             clk, reset_n, flush, in_valid, in_ready, sub, out_valid, out_ready;
    logic [FLEN-1:0]  a, b, result;
    logic [2:0]       rm;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [4:0]       fflags;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flags;
        logic [4:0]  tag;
    } expT;

    expT sbQ[$];
    expT monE;
    int checks   = 0;
    int failures = 0;

    fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
        .a(a), .b(b), .rm(rm), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .fflags(fflags), .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, expv);
        end
    endtask

    // Drive one operation and hold it until accepted; expected response is queued on accept
    task automatic applyStimulus(input logic [31:0] av, input logic [31:0] bv, input logic s,
                                 input logic [2:0] r, input logic [4:0] t,
                                 input logic [31:0] er, input logic [4:0] ef, input bit expectOut);
        bit acc;
        expT e;
        a = av; b = bv; sub = s; rm = r; in_tag = t; in_valid = 1'b1;
        acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout: tag %0d not accepted, expected acceptance", t);
        end else if (expectOut) begin
            e.res = er; e.flags = ef; e.tag = t;
            sbQ.push_back(e);
        end
    endtask

    task automatic waitDrain();
        for (int n = 0; n < 40 && sbQ.size() != 0; n++) @(posedge clk);
        #1;
        checkOutput("drain_pending", 32'(sbQ.size()), 32'd0);
    endtask

    // Monitor: each transfer pops the oldest expectation
    always @(negedge clk) begin
        if (reset_n && out_valid && out_ready) begin
            if (sbQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_output: got result 0x%08h tag %0d, expected none", result, out_tag);
            end else begin
                monE = sbQ.pop_front();
                checkOutput("result", result, monE.res);
                checkOutput("fflags", 32'(fflags), 32'(monE.flags));
                checkOutput("out_tag", 32'(out_tag), 32'(monE.tag));
            end
        end
    end

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        sub = 1'b0; a = '0; b = '0; rm = '0; in_tag = '0;
        #12;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_fflags", 32'(fflags), 32'd0);
        checkOutput("reset_out_tag", 32'(out_tag), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("post_reset_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Latency: result visible in the third cycle counting the accept cycle
        applyStimulus(32'h3F800000, 32'h40000000, 1'b0, 3'd0, 5'd1, 32'h40400000, 5'b00000, 1'b1);
        in_valid = 1'b0;
        @(negedge clk); checkOutput("latency_c1", 32'(out_valid), 32'd0);
        @(negedge clk); checkOutput("latency_c2", 32'(out_valid), 32'd0);
        @(negedge clk); checkOutput("latency_c3", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        // Directed vectors, back to back
        applyStimulus(32'h3F800000, 32'h33800000, 1'b0, 3'd0, 5'd2,  32'h3F800000, 5'b00001, 1'b1);
        applyStimulus(32'h3F800000, 32'h33800000, 1'b0, 3'd3, 5'd3,  32'h3F800001, 5'b00001, 1'b1);
        applyStimulus(32'h3F800000, 32'h33800000, 1'b0, 3'd4, 5'd4,  32'h3F800001, 5'b00001, 1'b1);
        applyStimulus(32'h3F800000, 32'h33800000, 1'b0, 3'd6, 5'd5,  32'h3F800000, 5'b00001, 1'b1);
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b1, 3'd0, 5'd6,  32'h00000000, 5'b00000, 1'b1);
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b1, 3'd2, 5'd7,  32'h80000000, 5'b00000, 1'b1);
        applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd0, 5'd8,  32'h7F800000, 5'b00101, 1'b1);
        applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd1, 5'd9,  32'h7F7FFFFF, 5'b00101, 1'b1);
        applyStimulus(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 3'd2, 5'd10, 32'h7F7FFFFF, 5'b00101, 1'b1);
        applyStimulus(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 3'd3, 5'd11, 32'hFF7FFFFF, 5'b00101, 1'b1);
        applyStimulus(32'h7F800000, 32'h7F800000, 1'b1, 3'd0, 5'd12, 32'h7FC00000, 5'b10000, 1'b1);
        applyStimulus(32'h7F800001, 32'h3F800000, 1'b0, 3'd0, 5'd13, 32'h7FC00000, 5'b10000, 1'b1);
        applyStimulus(32'h7FC00000, 32'h3F800000, 1'b0, 3'd0, 5'd14, 32'h7FC00000, 5'b00000, 1'b1);
        applyStimulus(32'h7F800000, 32'h3F800000, 1'b1, 3'd0, 5'd15, 32'h7F800000, 5'b00000, 1'b1);
        applyStimulus(32'h00000001, 32'h00000001, 1'b0, 3'd0, 5'd16, 32'h00000002, 5'b00000, 1'b1);
        applyStimulus(32'h00800000, 32'h00000001, 1'b1, 3'd0, 5'd17, 32'h007FFFFF, 5'b00000, 1'b1);
        applyStimulus(32'h80000000, 32'h80000000, 1'b0, 3'd0, 5'd18, 32'h80000000, 5'b00000, 1'b1);
        in_valid = 1'b0;
        waitDrain();

        // Backpressure: three accepts fill the pipe, then everything holds
        out_ready = 1'b0;
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b0, 3'd0, 5'd20, 32'h40000000, 5'b00000, 1'b1);
        applyStimulus(32'h40000000, 32'h40000000, 1'b0, 3'd0, 5'd21, 32'h40800000, 5'b00000, 1'b1);
        applyStimulus(32'h3F800000, 32'h40000000, 1'b0, 3'd0, 5'd22, 32'h40400000, 5'b00000, 1'b1);
        @(negedge clk);
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_result", result, 32'h40000000);
        fork
            begin
                applyStimulus(32'h40400000, 32'h3F800000, 1'b1, 3'd0, 5'd23, 32'h40000000, 5'b00000, 1'b1);
                applyStimulus(32'h40800000, 32'h3F800000, 1'b0, 3'd0, 5'd24, 32'h40A00000, 5'b00000, 1'b1);
                applyStimulus(32'h40000000, 32'h40800000, 1'b1, 3'd0, 5'd25, 32'hC0000000, 5'b00000, 1'b1);
            end
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    checkOutput("stall_hold_result", result, 32'h40000000);
                    checkOutput("stall_hold_tag", 32'(out_tag), 32'd20);
                    checkOutput("stall_hold_in_ready", 32'(in_ready), 32'd0);
                end
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        waitDrain();

        // Flush with two ops in flight; the op offered during flush is refused
        applyStimulus(32'h40800000, 32'h40800000, 1'b0, 3'd0, 5'd26, 32'h0, 5'b0, 1'b0);
        applyStimulus(32'h41000000, 32'h3F800000, 1'b0, 3'd0, 5'd27, 32'h0, 5'b0, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("flush_no_output", 32'(out_valid), 32'd0);
        end
        @(posedge clk); #1;

        // Asynchronous reset mid-stream: only the first op escapes before it
        applyStimulus(32'h3F800000, 32'h3F800000, 1'b0, 3'd0, 5'd28, 32'h40000000, 5'b00000, 1'b1);
        applyStimulus(32'h40000000, 32'h40000000, 1'b0, 3'd0, 5'd29, 32'h0, 5'b0, 1'b0);
        applyStimulus(32'h40400000, 32'h3F800000, 1'b0, 3'd0, 5'd30, 32'h0, 5'b0, 1'b0);
        applyStimulus(32'h40800000, 32'h3F800000, 1'b0, 3'd0, 5'd31, 32'h0, 5'b0, 1'b0);
        in_valid = 1'b0;
        checkOutput("pre_reset_out_valid", 32'(out_valid), 32'd1);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("async_reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_reset_result", result, 32'd0);
        checkOutput("async_reset_fflags", 32'(fflags), 32'd0);
        checkOutput("async_reset_out_tag", 32'(out_tag), 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_release_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        applyStimulus(32'h3F800000, 32'h40000000, 1'b0, 3'd0, 5'd3, 32'h40400000, 5'b00000, 1'b1);
        in_valid = 1'b0;
        waitDrain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
